// File: rtl/signed_step_counter_if.sv
// Button, load and display-side signals of signed_step_counter.
// The master drives the buttons and the load port. The slave (the counter) drives w,x,y,z, ovf and busy.
interface signed_step_counter_if;
    logic       inc_btn;
    logic       dec_btn;
    logic       load;
    logic [3:0] d;
    logic       w;
    logic       x;
    logic       y;
    logic       z;
    logic       ovf;
    logic       busy;

    modport master (
        output inc_btn, dec_btn, load, d,
        input  w, x, y, z, ovf, busy
    );

    modport slave (
        input  inc_btn, dec_btn, load, d,
        output w, x, y, z, ovf, busy
    );
endinterface

// File: rtl/signed_step_counter.sv
// signed_step_counter: holds a 4-bit two's-complement value (-8..+7) for the
// sign/magnitude seven-segment decoder.
// Each of the two push-buttons is synchronised and debounced. Every accepted press
// becomes a single increment or decrement of STEP.
// Build option SIGNED_STEP_SATURATE_EN: when defined, an out-of-range result clamps
// to +7 or -8. When undefined, it wraps modulo 16. ovf is set in both builds.
module signed_step_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP            = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    signed_step_counter_if.slave   bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NBTN  = 2;   // index 0 = inc, 1 = dec

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_e;

    logic [NBTN-1:0]  sync1_q;
    logic [NBTN-1:0]  sync2_q;
    btn_state_e       state_q [NBTN];
    btn_state_e       state_d [NBTN];
    logic [CNT_W-1:0] cnt_q   [NBTN];
    logic [CNT_W-1:0] cnt_d   [NBTN];
    logic [NBTN-1:0]  acc_q;
    logic [NBTN-1:0]  acc_d;
    logic [NBTN-1:0]  acc_prev_q;
    logic             busy_q;
    logic             busy_d;
    logic             inc_ev;
    logic             dec_ev;
    logic [3:0]       value_q;
    logic [3:0]       value_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [4:0]       value_ext;
    logic [4:0]       step_ext;
    logic [4:0]       sum_inc;
    logic [4:0]       sum_dec;

    // Two-flop synchronisers for the raw buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.dec_btn, bus.inc_btn};
            sync2_q <= sync1_q;
        end
    end

    // Debouncer state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debouncer next state: a differing level must persist until the counter reaches DEBOUNCE_CYCLES
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            acc_q[i]   = (state_q[i] == PRESSED);
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d[i] = (state_q[i] == PRESSED) ? RELEASED : PRESSED;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            acc_d[i] = (state_d[i] == PRESSED);
        end
        // busy is registered against the values that the synchroniser and debouncer take on at this same edge
        busy_d = |(sync1_q ^ acc_d);
    end

    // Edge-detector history and busy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_prev_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            acc_prev_q <= acc_q;
            busy_q     <= busy_d;
        end
    end

    assign inc_ev = acc_q[0] & ~acc_prev_q[0];
    assign dec_ev = acc_q[1] & ~acc_prev_q[1];

    // 5-bit signed step arithmetic. Bits 4 and 3 differing means the result is outside -8..+7.
    assign value_ext = {value_q[3], value_q};
    assign step_ext  = 5'(STEP);
    assign sum_inc   = value_ext + step_ext;
    assign sum_dec   = value_ext - step_ext;

    // Value update: load, then simultaneous events cancel, then inc, then dec
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (bus.load) begin
            value_d = bus.d;
            ovf_d   = 1'b0;
        end else if (inc_ev && dec_ev) begin
            value_d = value_q;
        end else if (inc_ev) begin
            value_d = sum_inc[3:0];
            if (sum_inc[4] != sum_inc[3]) begin
                ovf_d = 1'b1;
`ifdef SIGNED_STEP_SATURATE_EN
                value_d = 4'b0111;
`endif
            end
        end else if (dec_ev) begin
            value_d = sum_dec[3:0];
            if (sum_dec[4] != sum_dec[3]) begin
                ovf_d = 1'b1;
`ifdef SIGNED_STEP_SATURATE_EN
                value_d = 4'b1000;
`endif
            end
        end
    end

    // Value and overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.w    = value_q[3];
    assign bus.x    = value_q[2];
    assign bus.y    = value_q[1];
    assign bus.z    = value_q[0];
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_signed_step_counter.sv
// Directed bench for signed_step_counter with DEBOUNCE_CYCLES=4.
// u_dut uses STEP=1 and u_dut3 uses STEP=3.
// Expected values follow SIGNED_STEP_SATURATE_EN when it is defined.
`timescale 1ns/1ps
module tb_signed_step_counter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic busy_seen;

    signed_step_counter_if ifc ();
    signed_step_counter_if ifc3 ();

    signed_step_counter #(.DEBOUNCE_CYCLES(4), .STEP(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    signed_step_counter #(.DEBOUNCE_CYCLES(4), .STEP(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifc3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] val1();
        return 8'({ifc.w, ifc.x, ifc.y, ifc.z});
    endfunction

    function automatic logic [7:0] val3();
        return 8'({ifc3.w, ifc3.x, ifc3.y, ifc3.z});
    endfunction

    task automatic load1(input logic [3:0] v);
        ifc.load = 1'b1;
        ifc.d    = v;
        tick();
        ifc.load = 1'b0;
    endtask

    // Press the given buttons, hold them, release them and let the debouncers settle
    task automatic press1(input logic inc, input logic dec, input int hold);
        ifc.inc_btn = inc;
        ifc.dec_btn = dec;
        repeat (hold) tick();
        ifc.inc_btn = 1'b0;
        ifc.dec_btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int bounce_len [14] = '{1, 2, 3, 1, 2, 2, 3, 1, 1, 3, 2, 2, 3, 4};
        logic [7:0] exp_sat;
        n_checks  = 0;
        n_errors  = 0;
        busy_seen = 1'b0;
        rst = 1'b1;
        ifc.inc_btn  = 1'b0; ifc.dec_btn  = 1'b0; ifc.load  = 1'b0; ifc.d  = 4'h0;
        ifc3.inc_btn = 1'b0; ifc3.dec_btn = 1'b0; ifc3.load = 1'b0; ifc3.d = 4'h0;
        repeat (3) tick();
        check("reset_value", val1(), 8'h0);
        check("reset_ovf",   8'(ifc.ovf), 8'h0);
        check("reset_busy",  8'(ifc.busy), 8'h0);
        check("reset_value3", val3(), 8'h0);
        rst = 1'b0;
        tick();

        // Clean press: the step appears exactly 7 edges after the press is sampled
        ifc.inc_btn = 1'b1;
        repeat (7) tick();
        check("press_before_edge7", val1(), 8'h0);
        tick();
        check("press_at_edge7", val1(), 8'h1);
        repeat (12) tick();
        check("press_held_no_repeat", val1(), 8'h1);
        check("press_ovf", 8'(ifc.ovf), 8'h0);
        ifc.inc_btn = 1'b0;
        repeat (10) tick();
        check("release_no_step", val1(), 8'h1);
        check("release_busy_idle", 8'(ifc.busy), 8'h0);

        // Bounce: high pulses of 1-3 cycles only, so no press is accepted
        load1(4'h0);
        for (int i = 0; i < 14; i++) begin
            ifc.inc_btn = (i % 2 == 0);
            for (int j = 0; j < bounce_len[i]; j++) begin
                tick();
                if (ifc.busy) busy_seen = 1'b1;
            end
        end
        ifc.inc_btn = 1'b0;
        repeat (8) tick();
        check("bounce_value", val1(), 8'h0);
        check("bounce_busy_seen", 8'(busy_seen), 8'h1);
        check("bounce_busy_idle", 8'(ifc.busy), 8'h0);

        // +7 + 1: out of range
`ifdef SIGNED_STEP_SATURATE_EN
        exp_sat = 8'h7;
`else
        exp_sat = 8'h8;
`endif
        load1(4'b0111);
        check("load_0111", val1(), 8'h7);
        press1(1'b1, 1'b0, 10);
        check("ovf_inc_value", val1(), exp_sat);
        check("ovf_inc_flag", 8'(ifc.ovf), 8'h1);
        load1(4'b0000);
        check("load_clears_ovf", 8'(ifc.ovf), 8'h0);
        check("load_0000", val1(), 8'h0);

        // -8 - 3 with STEP=3: out of range
`ifdef SIGNED_STEP_SATURATE_EN
        exp_sat = 8'h8;
`else
        exp_sat = 8'h5;
`endif
        ifc3.load = 1'b1;
        ifc3.d    = 4'b1000;
        tick();
        ifc3.load = 1'b0;
        check("load3_1000", val3(), 8'h8);
        ifc3.dec_btn = 1'b1;
        repeat (10) tick();
        ifc3.dec_btn = 1'b0;
        repeat (10) tick();
        check("ovf_dec3_value", val3(), exp_sat);
        check("ovf_dec3_flag", 8'(ifc3.ovf), 8'h1);

        // Both buttons on the same edge cancel each other
        press1(1'b1, 1'b1, 12);
        check("both_pressed_value", val1(), 8'h0);
        check("both_pressed_busy", 8'(ifc.busy), 8'h0);

        // A load coinciding with a lone inc event wins; the event is dropped
        ifc.inc_btn = 1'b1;
        repeat (7) tick();
        ifc.load = 1'b1;
        ifc.d    = 4'b1110;
        tick();
        ifc.load = 1'b0;
        check("load_vs_event", val1(), 8'hE);
        repeat (3) tick();
        check("event_not_deferred", val1(), 8'hE);
        ifc.inc_btn = 1'b0;
        repeat (10) tick();

        // Reset during debounce clears immediately; the held button is then a fresh press
        load1(4'b0011);
        check("load_0011", val1(), 8'h3);
        ifc.inc_btn = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("async_rst_value", val1(), 8'h0);
        check("async_rst_ovf", 8'(ifc.ovf), 8'h0);
        tick();
        tick();
        rst = 1'b0;
        repeat (7) tick();
        check("post_rst_before_edge7", val1(), 8'h0);
        tick();
        check("post_rst_at_edge7", val1(), 8'h1);
        ifc.inc_btn = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
